// File: rtl/grid_arbiter.sv
// Round-robin sequencer sharing the single-port grid RAM between NREQ workers,
// with an atomic claim (test-and-set on EMPTY) and a bulk fill of every cell.
module grid_arbiter #(
    parameter int                 NREQ       = 4,
    parameter int                 GRID_CELLS = 36,
    parameter logic signed [31:0] EMPTY      = -32'sd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [32*NREQ-1:0]   addr,
    input  logic [32*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 claimed,
    output logic                 err,
    output logic                 busy,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout
);

    localparam int          IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]  OP_READ    = 2'b00;
    localparam logic [1:0]  OP_WRITE   = 2'b01;
    localparam logic [1:0]  OP_CLAIM   = 2'b10;
    localparam logic [1:0]  OP_FILL    = 2'b11;
    localparam logic [31:0] CELL_LIMIT = 32'(GRID_CELLS);
    localparam logic [31:0] LAST_CELL  = 32'(GRID_CELLS - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESOLVE,
        S_FILL,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] last_winner, winner, pick, cand;
    logic [1:0]    op_q;
    logic [31:0]   addr_q, wdata_q, cnt;
    logic [1:0]    op_a    [NREQ];
    logic [31:0]   addr_a  [NREQ];
    logic [31:0]   wdata_a [NREQ];
    logic          out_of_range, claim_hit;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            op_a[k]    = op[2*k +: 2];
            addr_a[k]  = addr[32*k +: 32];
            wdata_a[k] = wdata[32*k +: 32];
        end
    end

    // Scan downward so the requester closest after last_winner is the final (winning) assignment.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        pick = last_winner;
        cand = last_winner;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last_winner) + i) % NREQ);
            if (req[cand]) pick = cand;
        end
    end

    assign out_of_range = (addr_q >= CELL_LIMIT);
    assign claim_hit    = (op_q == OP_CLAIM) && ($signed(mem_dout) == EMPTY);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (|req) state_n = S_ISSUE;
            S_ISSUE: begin
                if (out_of_range && op_q != OP_FILL) state_n = S_DONE;
                else if (op_q == OP_WRITE)           state_n = S_DONE;
                else if (op_q == OP_FILL)            state_n = S_FILL;
                else                                 state_n = S_RESOLVE;
            end
            S_RESOLVE: state_n = S_DONE;
            S_FILL:    if (cnt == LAST_CELL) state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        done      = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_ISSUE: begin
                if (!(out_of_range && op_q != OP_FILL)) begin
                    if (op_q == OP_WRITE) begin
                        mem_write = 1'b1;
                        mem_addr  = addr_q;
                        mem_din   = wdata_q;
                    end else if (op_q == OP_READ || op_q == OP_CLAIM) begin
                        mem_read = 1'b1;
                        mem_addr = addr_q;
                    end
                end
            end
            // A claim whose RESOLVE cycle is hit by reset must leave the cell untouched.
            S_RESOLVE: begin
                if (claim_hit && !reset) begin
                    mem_write = 1'b1;
                    mem_addr  = addr_q;
                    mem_din   = wdata_q;
                end
            end
            S_FILL: begin
                mem_write = 1'b1;
                mem_addr  = cnt;
                mem_din   = wdata_q;
            end
            S_DONE:  done[winner] = 1'b1;
            default: ;
        endcase
    end

    // Result registers only change on the edge entering DONE, so they hold between completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= LAST_REQ;
            winner      <= '0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            grant       <= '0;
            rdata       <= '0;
            claimed     <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        winner  <= pick;
                        op_q    <= op_a[pick];
                        addr_q  <= addr_a[pick];
                        wdata_q <= wdata_a[pick];
                        grant   <= NREQ'(1) << pick;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                    if (out_of_range && op_q != OP_FILL) begin
                        err     <= 1'b1;
                        claimed <= 1'b0;
                    end else if (op_q == OP_WRITE) begin
                        err     <= 1'b0;
                        claimed <= 1'b0;
                    end
                end
                S_RESOLVE: begin
                    rdata   <= mem_dout;
                    claimed <= claim_hit;
                    err     <= 1'b0;
                end
                S_FILL: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == LAST_CELL) begin
                        err     <= 1'b0;
                        claimed <= 1'b0;
                    end
                end
                S_DONE: begin
                    last_winner <= winner;
                    grant       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_arbiter.sv
// Self-checking bench for grid_arbiter: directed vector table, hand-written reset and
// fairness sequences, then randomized traffic scored against a behavioural grid model.
module tb_grid_arbiter;

    localparam int NREQ = 4;
    localparam int GC   = 36;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   op;
    logic [32*NREQ-1:0]  addr, wdata;
    logic [NREQ-1:0]     grant, done;
    logic [31:0]         rdata;
    logic                claimed, err, busy, mem_read, mem_write;
    logic [31:0]         mem_addr, mem_din;
    logic [31:0]         mem_dout = '0;

    grid_arbiter #(.NREQ(NREQ), .GRID_CELLS(GC), .EMPTY(-32'sd1)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .grant(grant), .done(done), .rdata(rdata), .claimed(claimed), .err(err),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Grid RAM stand-in: registered read, write on the edge.
    logic [31:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[5:0]] <= mem_din;
        if (mem_read)  mem_dout <= ram[mem_addr[5:0]];
    end

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t wr_log[$];
    int  overlap = 0;
    always @(negedge clk) begin
        if (mem_write) wr_log.push_back({mem_addr, mem_din});
        if (mem_read && mem_write) overlap++;
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural model: the grid as an array plus the observable result registers.
    logic [31:0] grid [GC];
    logic [31:0] m_rdata;
    logic        m_claimed, m_err;
    int          m_last;
    wr_t         exp_w[$];

    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
        for (int i = 1; i <= NREQ; i++)
            if (mask[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NREQ - 1; m_rdata = '0; m_claimed = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                               output int lat);
        exp_w = {};
        m_claimed = 1'b0;
        m_err = 1'b0;
        lat = 2;
        if (o != 2'd3 && a >= 32'(GC)) begin
            m_err = 1'b1;
        end else begin
            case (o)
                2'd0: begin m_rdata = grid[int'(a)]; lat = 3; end
                2'd1: begin grid[int'(a)] = d; exp_w.push_back({a, d}); end
                2'd2: begin
                    m_rdata = grid[int'(a)];
                    lat = 3;
                    if (grid[int'(a)] == 32'hFFFF_FFFF) begin
                        grid[int'(a)] = d; m_claimed = 1'b1; exp_w.push_back({a, d});
                    end
                end
                default: begin
                    for (int i = 0; i < GC; i++) begin grid[i] = d; exp_w.push_back({32'(i), d}); end
                    lat = GC + 2;
                end
            endcase
        end
    endtask

    task automatic set_fields(input int k, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        op[2*k +: 2] = o; addr[32*k +: 32] = a; wdata[32*k +: 32] = d;
    endtask

    task automatic scramble_fields();
        for (int k = 0; k < NREQ; k++) set_fields(k, 2'd1, 32'd9, $urandom);
    endtask

    // Starts on an IDLE-cycle negedge (cycle 0); returns at the negedge where done is seen.
    task automatic run_txn(input logic [NREQ-1:0] mask, input bit scramble, output int lat,
                           output logic [NREQ-1:0] g1, output logic [NREQ-1:0] dn, output int ws);
        @(negedge clk);
        req = mask; ws = wr_log.size(); lat = 0; g1 = '0; dn = '0;
        while (lat < 100 && dn == '0) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin g1 = grant; if (scramble) scramble_fields(); end
            dn = done;
        end
        req = '0;
        check("done_seen", 32'(|dn), 32'd1);
    endtask

    task automatic check_writes(input int ws);
        int n, bad;
        n = wr_log.size() - ws;
        bad = 0;
        check("wr_count", n, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < n; i++)
            if (wr_log[ws + i] !== exp_w[i]) bad++;
        check("wr_content", bad, 0);
    endtask

    task automatic check_txn(input int w, input int mlat, input int lat, input logic [NREQ-1:0] g1,
                             input logic [NREQ-1:0] dn, input int ws);
        check("grant", g1, NREQ'(1) << w);
        check("done", dn, NREQ'(1) << w);
        check("latency", lat, mlat);
        check("rdata", rdata, m_rdata);
        check("claimed", claimed, m_claimed);
        check("err", err, m_err);
        check_writes(ws);
        m_last = w;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_claimed"}, claimed, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_din"}, mem_din, 0);
    endtask

    typedef struct {
        int k; logic [1:0] o; logic [31:0] a; logic [31:0] d;
        int lat; logic [31:0] rd; logic cl; logic er; int nw;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, ws, w, mlat, cyc;
        logic [NREQ-1:0] g1, dn, mask;
        logic [1:0]  ro [NREQ];
        logic [31:0] ra [NREQ], rd [NREQ];

        vecs[0] = '{0, 2'd3, 32'd0,  32'hFFFF_FFFF, 38, 32'd0,         1'b0, 1'b0, 36};
        vecs[1] = '{1, 2'd2, 32'd7,  32'd3,         3,  32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        vecs[2] = '{2, 2'd2, 32'd7,  32'd9,         3,  32'd3,         1'b0, 1'b0, 0};
        vecs[3] = '{3, 2'd1, 32'd36, 32'd5,         2,  32'd3,         1'b0, 1'b1, 0};
        vecs[4] = '{0, 2'd0, 32'd35, 32'd0,         3,  32'hFFFF_FFFF, 1'b0, 1'b0, 0};
        vecs[5] = '{1, 2'd1, 32'd10, 32'd42,        2,  32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[6] = '{2, 2'd0, 32'd10, 32'd0,         3,  32'd42,        1'b0, 1'b0, 0};
        vecs[7] = '{3, 2'd2, 32'd40, 32'd1,         2,  32'd42,        1'b0, 1'b1, 0};
        vecs[8] = '{3, 2'd0, 32'd7,  32'd0,         3,  32'd3,         1'b0, 1'b0, 0};
        vecs[9] = '{0, 2'd1, 32'd35, 32'hFFFF_FFFB, 2,  32'd3,         1'b0, 1'b0, 1};

        for (int i = 0; i < GC; i++) grid[i] = '0;
        reset = 1'b1; req = '0; op = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        model_reset();

        // Directed vectors, each from a single requester.
        for (int i = 0; i < 10; i++) begin
            set_fields(vecs[i].k, vecs[i].o, vecs[i].a, vecs[i].d);
            model_apply(vecs[i].o, vecs[i].a, vecs[i].d, mlat);
            run_txn(NREQ'(1) << vecs[i].k, 1'b0, lat, g1, dn, ws);
            check("vec_grant", g1, NREQ'(1) << vecs[i].k);
            check("vec_done", dn, NREQ'(1) << vecs[i].k);
            check("vec_latency", lat, vecs[i].lat);
            check("vec_rdata", rdata, vecs[i].rd);
            check("vec_claimed", claimed, vecs[i].cl);
            check("vec_err", err, vecs[i].er);
            check("vec_nwrites", wr_log.size() - ws, vecs[i].nw);
            check_writes(ws);
            m_last = vecs[i].k;
        end

        // All four requesting continuously: strict rotation with one dead cycle between.
        for (int k = 0; k < NREQ; k++) set_fields(k, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        req = '1;
        for (int t = 0; t < 8; t++) begin
            w = rr_pick('1, m_last);
            cyc = 0; dn = '0;
            while (cyc < 10 && dn == '0) begin @(negedge clk); cyc++; dn = done; end
            check("rr_done", dn, NREQ'(1) << w);
            check("rr_latency", cyc, 3);
            check("rr_rdata", rdata, grid[0]);
            m_last = w; m_rdata = grid[0]; m_claimed = 1'b0; m_err = 1'b0;
            if (t == 7) req = '0;
            @(negedge clk);
            check("rr_dead_busy", busy, 0);
            check("rr_done_pulse", done, 0);
        end

        // Inputs changed right after grant must not affect the latched read.
        set_fields(0, 2'd0, 32'd5, 32'd0);
        model_apply(2'd0, 32'd5, 32'd0, mlat);
        run_txn(4'b0001, 1'b1, lat, g1, dn, ws);
        check_txn(0, mlat, lat, g1, dn, ws);

        // Reset at the 10th FILL cycle (cycle 11).
        set_fields(0, 2'd3, 32'd0, 32'd5);
        @(negedge clk);
        req = 4'b0001;
        repeat (11) @(negedge clk);
        check("midfill_busy", busy, 1);
        check("midfill_addr", mem_addr, 9);
        reset = 1'b1; req = '0;
        @(negedge clk);
        check_idle("fillrst");
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 9; i++) grid[i] = 32'd5;

        set_fields(1, 2'd0, 32'd20, 32'd0);
        set_fields(3, 2'd0, 32'd0, 32'd0);
        w = rr_pick(4'b1010, m_last);
        model_apply(2'd0, 32'd20, 32'd0, mlat);
        run_txn(4'b1010, 1'b0, lat, g1, dn, ws);
        check_txn(w, mlat, lat, g1, dn, ws);
        set_fields(3, 2'd0, 32'd0, 32'd0);
        model_apply(2'd0, 32'd0, 32'd0, mlat);
        run_txn(4'b1000, 1'b0, lat, g1, dn, ws);
        check_txn(3, mlat, lat, g1, dn, ws);
        set_fields(2, 2'd3, 32'd0, 32'hFFFF_FFFF);
        model_apply(2'd3, 32'd0, 32'hFFFF_FFFF, mlat);
        run_txn(4'b0100, 1'b0, lat, g1, dn, ws);
        check_txn(2, mlat, lat, g1, dn, ws);

        // Reset during RESOLVE of a winning claim: the cell must stay EMPTY.
        set_fields(2, 2'd2, 32'd12, 32'd8);
        @(negedge clk);
        req = 4'b0100; ws = wr_log.size();
        repeat (2) @(negedge clk);
        check("resolve_busy", busy, 1);
        reset = 1'b1; req = '0;
        @(negedge clk);
        check_idle("claimrst");
        check("claimrst_nowrite", wr_log.size() - ws, 0);
        reset = 1'b0;
        model_reset();
        set_fields(0, 2'd0, 32'd12, 32'd0);
        model_apply(2'd0, 32'd12, 32'd0, mlat);
        run_txn(4'b0001, 1'b0, lat, g1, dn, ws);
        check_txn(0, mlat, lat, g1, dn, ws);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = $urandom_range(0, 99);
                ro[k] = (r < 35) ? 2'd0 : (r < 65) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
                ra[k] = 32'($urandom_range(0, 39));
                rd[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                set_fields(k, ro[k], ra[k], rd[k]);
            end
            w = rr_pick(mask, m_last);
            model_apply(ro[w], ra[w], rd[w], mlat);
            run_txn(mask, 1'b1, lat, g1, dn, ws);
            check_txn(w, mlat, lat, g1, dn, ws);
        end

        check("strobe_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
